mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access unit for the MEM stage of the pipelined MIPS core. Consumes the 2-bit MemRead/MemWrite size codes emitted by the instruction decoder (lb/lh/lw, sb/sh/sw), drives a word-wide, variable-latency memory bus with byte enables, sign-extends load data, and stalls the pipeline until each access completes or times out.

## Interface
- TIMEOUT_CYCLES, 255: bus cycles to wait for `bus_ack` before abandoning the access; range 1..255.
- clk  in  1  pipeline clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  2  load size from EX/MEM: 00 none, 01 byte, 10 half, 11 word
- mem_write  in  2  store size, same encoding
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data, right-aligned in bits [7:0]/[15:0]/[31:0]
- rdata  out  32  sign-extended load result; valid only while `done`
- done  out  1  one-cycle pulse; access finished this cycle
- err  out  1  valid with `done`: timeout (or misalignment, see Configuration)
- stall  out  1  freeze IF..EX/MEM registers while high
- bus_req  out  1  transfer request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  30  word address = addr[31:2]
- bus_be  out  4  byte enables, lane i = bits [8i+7:8i], little-endian
- bus_wdata  out  32  store data replicated to the selected lanes
- bus_rdata  in  32  read word, sampled on the ack cycle
- bus_ack  in  1  one-cycle completion strobe

## Operation
- States: IDLE, BUS, DONE.
- IDLE: request = (mem_read != 00) | (mem_write != 00). On request: register size, direction, addr, wdata; go BUS. If both are nonzero, the write wins and the read is ignored.
- BUS: bus_req=1 with stable bus_we/addr/be/wdata. On bus_ack: latch bus_rdata, go DONE, err=0. If the timeout counter reaches TIMEOUT_CYCLES without ack: go DONE, err=1, rdata=0.
- DONE: done=1, stall=0; return to IDLE unconditionally. Inputs are ignored in this cycle, because the pipeline advances on the edge that ends DONE.
- Byte enables: byte → 0001 << addr[1:0]; half → 0011 << {addr[1],0}; word → 1111.
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load: select the lane(s) given by the registered addr, then sign-extend to 32 bits (lb/lh are signed; no unsigned loads).
- Timeout counter: 8-bit; cleared on entry to BUS; increments in each BUS cycle without ack.
- stall = (IDLE & request) | BUS. It is combinational, so it rises in the same cycle the request appears.

## Timing
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, rdata 0, done 0, err 0, stall 0, counter 0.
- Reset is asynchronous: it drops bus_req immediately mid-transfer. A late ack after reset is ignored.
- Minimum latency with ack in the first BUS cycle is 3 cycles (IDLE, BUS, DONE), so stall is high for 2 cycles.
- An ack of N cycles gives N+2 cycles total.
- An ack arriving on the same edge the counter expires is treated as success.
- bus_ack outside BUS is ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - These accesses are misaligned: half with addr[0]=1; word with addr[1:0]≠00.
  - A misaligned access goes IDLE→DONE with no bus transaction (bus_req stays 0), err=1, rdata=0.
  - stall is high for 1 cycle only.
- MEM_ALIGN_CHECK_EN undefined:
  - The low address bits are forced to natural alignment: addr[0] for half; addr[1:0] for word.
  - The access always proceeds, and err means timeout only.

## Structure
- Shared package `mem_pkg`:
  - Size codes MEM_NONE=2'b00, MEM_BYTE=2'b01, MEM_HALF=2'b10, MEM_WORD=2'b11. These match the decoder's MemRead/MemWrite encoding.
  - State enum {IDLE, BUS, DONE}.
- One combinational sub-module, `mem_load_align`: inputs are the word, addr[1:0] and size; output is the sign-extended 32-bit load value.

## Test plan
- lw at 0x0000_1004, ack after 2 BUS cycles, bus_rdata 0xDEAD_BEEF:
  - bus_addr 0x401, be 1111, we 0.
  - stall high 4 cycles, then done with rdata 0xDEAD_BEEF, err 0.
- lb at addr 0x…03, bus_rdata 0x80_12_34_56:
  - be 1000, rdata 0xFFFF_FF80.
  - lh at 0x…02 on the same word: be 1100, rdata 0xFFFF_8012.
- sh of wdata 0x0000_ABCD at 0x…02: bus_we 1, be 1100, bus_wdata 0xABCD_ABCD. Repeat with sb of 0x77 at 0x…01: be 0010, bus_wdata 0x7777_7777.
- No ack with TIMEOUT_CYCLES=4: bus_req high 4 cycles, then done with err 1, rdata 0, and bus_req low in DONE.
- lw at 0x…02:
  - With MEM_ALIGN_CHECK_EN: no bus_req, done+err next cycle, stall high 1 cycle.
  - Without the macro: bus_addr unchanged, be 1111, err 0.
- Asserting rst in the middle of BUS: bus_req and stall drop immediately. After release, a stray ack produces no done, and a new lw completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: decoder size codes, FSM
// states and byte-lane helpers.
package mem_pkg;

    typedef logic [1:0] mem_size_t;

    localparam mem_size_t MEM_NONE = 2'b00;
    localparam mem_size_t MEM_BYTE = 2'b01;
    localparam mem_size_t MEM_HALF = 2'b10;
    localparam mem_size_t MEM_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Lane mask for an access whose low address bits are already aligned.
    function automatic logic [3:0] byte_enables(input mem_size_t size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b0001 << lo;
            MEM_HALF: be = 4'b0011 << {lo[1], 1'b0};
            MEM_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate_wdata(input mem_size_t size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            MEM_BYTE: rep = {4{data[7:0]}};
            MEM_HALF: rep = {2{data[15:0]}};
            default:  rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a bus word and sign-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    output logic [31:0] value
);

    logic [7:0] lane [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = lane[addr_lo];
        sel_half = addr_lo[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};
        case (size)
            MEM_BYTE: value = {{24{sel_byte[7]}}, sel_byte};
            MEM_HALF: value = {{16{sel_half[15]}}, sel_half};
            default:  value = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: word bus with byte enables, stall and timeout.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses instead of aligning them.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_reg;
    mem_size_t  size_reg;
    logic [1:0] addr_lo_reg;
    logic       write_reg;
    logic [7:0] count_reg;

    logic       request;
    logic       is_write;
    mem_size_t  req_size;
    logic [1:0] eff_lo;
    logic       misaligned;
    logic [31:0] load_value;

    always_comb begin
        request  = (mem_read != MEM_NONE) || (mem_write != MEM_NONE);
        is_write = (mem_write != MEM_NONE);
        req_size = is_write ? mem_write : mem_read;
        case (req_size)
            MEM_HALF: eff_lo = {addr[1], 1'b0};
            MEM_WORD: eff_lo = 2'b00;
            default:  eff_lo = addr[1:0];
        endcase
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = ((req_size == MEM_HALF) && addr[0]) ||
                     ((req_size == MEM_WORD) && (addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    // Reset masks stall so the pipeline is released the moment reset hits.
    assign stall = ~rst & (((state_reg == IDLE) && request) || (state_reg == BUS));

    mem_load_align u_align (
        .word    (bus_rdata),
        .addr_lo (addr_lo_reg),
        .size    (size_reg),
        .value   (load_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            size_reg    <= MEM_NONE;
            addr_lo_reg <= 2'b00;
            write_reg   <= 1'b0;
            count_reg   <= 8'd0;
            rdata       <= 32'd0;
            done        <= 1'b0;
            err         <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 30'd0;
            bus_be      <= 4'd0;
            bus_wdata   <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (request) begin
                        size_reg    <= req_size;
                        addr_lo_reg <= eff_lo;
                        write_reg   <= is_write;
                        count_reg   <= 8'd0;
                        if (misaligned) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            rdata     <= 32'd0;
                        end else begin
                            state_reg <= BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= is_write;
                            bus_addr  <= addr[31:2];
                            bus_be    <= byte_enables(req_size, eff_lo);
                            bus_wdata <= replicate_wdata(req_size, wdata);
                        end
                    end
                end
                BUS: begin
                    // Ack wins over an expiry on the same edge.
                    if (bus_ack) begin
                        state_reg <= DONE;
                        bus_req   <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b0;
                        rdata     <= write_reg ? 32'd0 : load_value;
                    end else if (count_reg == LAST_COUNT) begin
                        state_reg <= DONE;
                        bus_req   <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        rdata     <= 32'd0;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    err       <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases plus random accesses
// checked against a lane/sign-extension reference model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mem_read = 2'b00;
    logic [1:0]  mem_write = 2'b00;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ack_at: BUS cycle (1-based) in which ack is driven; 0 = never.
    task automatic access(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word, input int ack_at);
        logic [1:0]  sz;
        logic        isw;
        logic        mis;
        int          off;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] shifted;
        logic [31:0] exp_rd;
        int          exp_cyc;
        logic        exp_err;
        int          bus_cyc;
        int          stall_cnt;
        logic        got_done;
        logic [31:0] got_rd;
        logic        got_err;

        isw = (wr != 2'b00);
        sz  = isw ? wr : rd;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((sz == 2'd2) && a[0]) || ((sz == 2'd3) && (a[1:0] != 2'b00));
`endif
        if (sz == 2'd1)      off = int'(a[1:0]);
        else if (sz == 2'd2) off = a[1] ? 2 : 0;
        else                 off = 0;
        if (sz == 2'd1)      exp_be = 4'(1 << off);
        else if (sz == 2'd2) exp_be = 4'(3 << off);
        else                 exp_be = 4'hF;
        if (sz == 2'd1)      exp_wd = {4{wd[7:0]}};
        else if (sz == 2'd2) exp_wd = {2{wd[15:0]}};
        else                 exp_wd = wd;
        shifted = word >> (8 * off);
        if (sz == 2'd1)      exp_rd = 32'($signed(shifted[7:0]));
        else if (sz == 2'd2) exp_rd = 32'($signed(shifted[15:0]));
        else                 exp_rd = word;
        if (mis) begin
            exp_cyc = 0;
            exp_err = 1'b1;
        end else if (ack_at >= 1 && ack_at <= TO) begin
            exp_cyc = ack_at;
            exp_err = 1'b0;
        end else begin
            exp_cyc = TO;
            exp_err = 1'b1;
        end
        if (exp_err) exp_rd = 32'd0;

        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        bus_ack   = 1'b0;
        #1 check("stall_on_request", 32'(stall), 32'd1);
        stall_cnt = 1;
        bus_cyc   = 0;
        got_done  = 1'b0;
        got_rd    = 32'd0;
        got_err   = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                got_rd   = rdata;
                got_err  = err;
                check("err", 32'(err), 32'(exp_err));
                if (!isw) check("rdata", rdata, exp_rd);
                check("bus_req_in_done", 32'(bus_req), 32'd0);
                mem_read  = 2'b00;
                mem_write = 2'b00;
                bus_ack   = 1'b0;
                #1 check("stall_in_done", 32'(stall), 32'd0);
            end else begin
                if (bus_req) begin
                    bus_cyc++;
                    if (bus_cyc == 1) begin
                        check("bus_we", 32'(bus_we), 32'(isw));
                        check("bus_addr", 32'(bus_addr), 32'(a[31:2]));
                        check("bus_be", 32'(bus_be), 32'(exp_be));
                        if (isw) check("bus_wdata", bus_wdata, exp_wd);
                    end
                    if (bus_cyc == ack_at) begin
                        bus_ack   = 1'b1;
                        bus_rdata = word;
                    end else begin
                        bus_ack   = 1'b0;
                        bus_rdata = $urandom;
                    end
                end else begin
                    bus_ack = 1'b0;
                end
                #1 if (stall) stall_cnt++;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("bus_cycles", 32'(bus_cyc), 32'(exp_cyc));
        check("stall_cycles", 32'(stall_cnt), 32'(exp_cyc + 1));
        @(negedge clk);
        check("done_pulse_1cyc", 32'(done), 32'd0);
        $display("[TB] rd=%0d wr=%0d addr=%h wdata=%h ack_at=%0d -> cycles=%0d rdata=%h err=%0d",
                 rd, wr, a, wd, ack_at, bus_cyc, got_rd, got_err);
    endtask

    initial begin
        #1;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed plan cases
        access(2'b11, 2'b00, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 3);
        access(2'b01, 2'b00, 32'h0000_2003, 32'd0, 32'h8012_3456, 1);
        access(2'b10, 2'b00, 32'h0000_2002, 32'd0, 32'h8012_3456, 2);
        access(2'b00, 2'b10, 32'h0000_3002, 32'h0000_ABCD, 32'd0, 1);
        access(2'b00, 2'b01, 32'h0000_3001, 32'h0000_0077, 32'd0, 2);
        access(2'b11, 2'b00, 32'h0000_4000, 32'd0, 32'h1234_5678, 0);
        access(2'b11, 2'b00, 32'h0000_4000, 32'd0, 32'h1234_5678, TO);
        access(2'b11, 2'b00, 32'h0000_5002, 32'd0, 32'hCAFE_F00D, 1);
        access(2'b10, 2'b11, 32'h0000_6001, 32'h5555_AAAA, 32'd0, 1);

        // Reset in the middle of a bus transfer
        @(negedge clk);
        mem_read = 2'b11;
        addr     = 32'h0000_7000;
        @(negedge clk);
        @(negedge clk);
        check("bus_req_before_rst", 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("bus_req_async_rst", 32'(bus_req), 32'd0);
        check("stall_async_rst", 32'(stall), 32'd0);
        mem_read = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("stray_ack_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("stray_ack_no_done2", 32'(done), 32'd0);
        access(2'b11, 2'b00, 32'h0000_7000, 32'd0, 32'h0BAD_F00D, 1);

        // Random accesses
        for (int n = 0; n < 40; n++) begin
            logic [1:0] rd;
            logic [1:0] wr;
            rd = 2'($urandom_range(0, 3));
            wr = 2'($urandom_range(0, 3));
            if (rd == 2'b00 && wr == 2'b00) rd = 2'b11;
            access(rd, wr, $urandom, $urandom, $urandom, int'($urandom_range(0, TO + 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
